// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctangent table and leading-one helper for the CORDIC cosine
package cordic_pkg;

    localparam int ITERATIONS = 14;
    localparam int FRAC_BITS  = 22;
    localparam int DATA_W     = 24;

    localparam logic signed [DATA_W-1:0] K = 24'sd2547004;

    function automatic logic signed [DATA_W-1:0] atan_lut(input int i);
        case (i)
            0:       return 24'sd3294199;
            1:       return 24'sd1944679;
            2:       return 24'sd1027515;
            3:       return 24'sd521583;
            4:       return 24'sd261803;
            5:       return 24'sd131029;
            6:       return 24'sd65531;
            7:       return 24'sd32767;
            8:       return 24'sd16384;
            9:       return 24'sd8192;
            10:      return 24'sd4096;
            11:      return 24'sd2048;
            12:      return 24'sd1024;
            13:      return 24'sd512;
            14:      return 24'sd256;
            default: return 24'sd128;
        endcase
    endfunction

    function automatic int msb_pos(input logic [DATA_W-1:0] v);
        int p;
        p = 0;
        for (int b = 0; b < DATA_W; b++)
            if (v[b]) p = b;
        return p;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered rotation-mode CORDIC micro-rotation with shift index SHIFT
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic                     clk_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] z,
    output logic signed [DATA_W-1:0] xq,
    output logic signed [DATA_W-1:0] yq,
    output logic signed [DATA_W-1:0] zq
);

    localparam logic signed [DATA_W-1:0] ANGLE = atan_lut(SHIFT);

    logic neg;
    assign neg = z[DATA_W-1];

    always_ff @(posedge clock)
        if (aclr) begin
            xq <= '0;
            yq <= '0;
            zq <= '0;
        end else if (clk_en) begin
            xq <= neg ? x + (y >>> SHIFT) : x - (y >>> SHIFT);
            yq <= neg ? y - (x >>> SHIFT) : y + (x >>> SHIFT);
            zq <= neg ? z + ANGLE : z - ANGLE;
        end

endmodule

// File: rtl/cordic_cos_unrolled.sv
// cordic_cos_unrolled: pipelined float-in/float-out cos(x) built from an unrolled CORDIC
module cordic_cos_unrolled
    import cordic_pkg::*;
(
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    output logic [31:0] result
);

    logic [30:0] mag;
    logic [7:0] e;
    logic [23:0] sig;
    logic signed [DATA_W-1:0] angle;
    logic signed [DATA_W-1:0] x0, y0, z0;
    logic signed [DATA_W-1:0] xs [ITERATIONS+1];
    logic signed [DATA_W-1:0] ys [ITERATIONS+1];
    logic signed [DATA_W-1:0] zs [ITERATIONS+1];
    logic signed [DATA_W-1:0] y_unused, z_unused;
    logic signed [DATA_W-1:0] xf;
    logic [DATA_W-1:0] norm;
    logic [7:0] ex;
    logic [22:0] mant;

    // cos is even, so the sign bit is masked away before range reduction
    assign mag = 31'(dataa & 32'h7FFF_FFFF);
    assign e = mag[30:23];
    assign sig = {1'b1, mag[22:0]};

    // anything above 1.0 (including Inf/NaN) clamps to exactly 1.0 rad
    always_comb
        angle = mag > 31'h3F80_0000 ? DATA_W'(1 << FRAC_BITS)
              : e < 8'(127 - FRAC_BITS) ? '0
              : DATA_W'(sig >> (8'd150 - e - 8'(FRAC_BITS)));

    always_ff @(posedge clock)
        if (aclr) begin
            x0 <= '0;
            y0 <= '0;
            z0 <= '0;
        end else if (clk_en) begin
            x0 <= K;
            y0 <= '0;
            z0 <= angle;
        end

    assign xs[0] = x0;
    assign ys[0] = y0;
    assign zs[0] = z0;

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
        cordic_stage #(.SHIFT(i)) u_stage (
            .clock (clock),
            .aclr  (aclr),
            .clk_en(clk_en),
            .x     (xs[i]),
            .y     (ys[i]),
            .z     (zs[i]),
            .xq    (xs[i+1]),
            .yq    (ys[i+1]),
            .zq    (zs[i+1])
        );
    end

    // only the cosine term leaves the pipeline
    assign y_unused = ys[ITERATIONS];
    assign z_unused = zs[ITERATIONS];
    assign xf = xs[ITERATIONS];

    // shift the leading one out the top so the remaining bits are the left-aligned mantissa
    always_comb begin
        norm = xf << (DATA_W - msb_pos(xf));
        mant = 23'({norm, 23'b0} >> DATA_W);
        ex = 8'(127 - FRAC_BITS + msb_pos(xf));
    end

    always_ff @(posedge clock)
        if (aclr) result <= '0;
        else if (clk_en) result <= (xf[DATA_W-1] || xf == '0) ? 32'h0 : {1'b0, ex, mant};

endmodule

// File: tb/tb_cordic_cos_unrolled.sv
// tb_cordic_cos_unrolled: vector table plus scoreboard check of the pipelined CORDIC cosine
module tb_cordic_cos_unrolled;

    logic        clock = 1'b0;
    logic        aclr = 1'b1;
    logic        clk_en = 1'b0;
    logic [31:0] dataa = 32'h0;
    logic [31:0] result;

    cordic_cos_unrolled dut (
        .clock (clock),
        .aclr  (aclr),
        .clk_en(clk_en),
        .dataa (dataa),
        .result(result)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a;
        int          ppm;
    } vec_t;

    typedef struct packed {
        int ppm;
        int due;
    } sb_t;

    sb_t  q[$];
    vec_t vt[11];
    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    int   rcnt = 0;
    int   cur_ppm = 0;
    logic vld = 1'b0;

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  ex;
        ex = int'(b[30:23]);
        if (ex == 0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int k = 127; k < ex; k++) v = v * 2.0;
        for (int k = ex; k < 127; k++) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    task automatic check_val(input string name, input real want);
        real got;
        got = f2r(result);
        total++;
        if (result[31] || got - want > 1.0e-3 || want - got > 1.0e-3) begin
            bad++;
            $display("FAIL %s: result=%h (%f) expected %f", name, result, got, want);
        end
    endtask

    task automatic check_bits(input string name, input logic [31:0] want);
        total++;
        if (result !== want) begin
            bad++;
            $display("FAIL %s: result=%h expected %h", name, result, want);
        end
    endtask

    // one clock: book the operand in the scoreboard, then sample 1ns after the edge
    task automatic tick();
        if (aclr) begin
            q.delete();
            rcnt = 0;
        end else if (clk_en) begin
            ecnt++;
            rcnt++;
            if (vld) q.push_back('{ppm: cur_ppm, due: ecnt + 15});
        end
        @(posedge clock);
        #1;
        if (aclr) check_bits("reset", 32'h0);
        else if (q.size() > 0 && q[0].due == ecnt) begin
            check_val("cos", real'(q[0].ppm) / 1.0e6);
            void'(q.pop_front());
        end else if (rcnt <= 15) check_bits("flush", 32'h0);
    endtask

    task automatic put(input logic [31:0] a, input int p);
        dataa = a;
        cur_ppm = p;
        vld = 1'b1;
        tick();
    endtask

    task automatic drain();
        vld = 1'b0;
        for (int k = 0; k < 60 && q.size() > 0; k++) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        vt[0]  = '{32'h00000000, 1000000};
        vt[1]  = '{32'h3DCCCCCD, 995004};
        vt[2]  = '{32'h3F000000, 877583};
        vt[3]  = '{32'h3F800000, 540302};
        vt[4]  = '{32'hBF000000, 877583};
        vt[5]  = '{32'h40000000, 540302};
        vt[6]  = '{32'h7FC00000, 540302};
        vt[7]  = '{32'h7F800000, 540302};
        vt[8]  = '{32'h00000001, 1000000};
        vt[9]  = '{32'h33000000, 1000000};
        vt[10] = '{32'h3F333333, 764842};

        repeat (2) tick();
        aclr = 1'b0;
        clk_en = 1'b1;
        put(32'h3F333333, 764842);
        drain();

        for (int k = 0; k < 11; k++) put(vt[k].a, vt[k].ppm);
        drain();

        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            a = {1'b0, 8'($urandom_range(118, 126)), 23'($urandom)};
            clk_en = ($urandom_range(0, 3) != 0);
            put(a, int'($cos(f2r(a)) * 1.0e6));
        end
        clk_en = 1'b1;
        drain();

        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        put(32'h3F333333, 764842);
        vld = 1'b0;
        dataa = 32'h0;
        repeat (6) tick();
        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        drain();

        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        put(32'h3E99999A, 955336);
        vld = 1'b0;
        repeat (6) tick();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        for (int k = 0; k < 20; k++) put(32'h3F800000, 540302);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
